pulse_width_meter: RTL
======================

# pulse_width_meter

Measures the high time of a slow external pulse, for example an ultrasonic echo, in prescaled ticks of the system clock. It is the receive-side counterpart of the clock divider: instead of dividing ClockIn down to produce a slow waveform, it times a slow waveform against a divided ClockIn. It sits between an input pin and the distance/LED display logic. Results are reported with a one-cycle Done strobe.

## Interface
- PRESCALE, 50: ClockIn cycles per measurement tick (50 MHz gives 1 µs per tick); legal range ≥ 2.
- WIDTH, 16: width of the tick counter and of the Width output.
- TIMEOUT, 30000: tick limit for both the wait-for-rise phase and the measure phase; must satisfy TIMEOUT < 2^WIDTH.
- ClockIn  input  1  system clock; every flop is clocked on the rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle arm request; honoured only in IDLE.
- PulseIn  input  1  asynchronous pulse being measured.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle strobe; Width and Timeout are valid while it is high.
- Width  output  WIDTH  measured tick count; held until the next Done.
- Timeout  output  1  1 = the last measurement timed out; held until the next Done.

## Operation
- PulseIn passes through a two-flop synchronizer (s1, s2). A third flop (s3) holds the previous value of s2.
- Edge detection: rise = s2 & ~s3; fall = ~s2 & s3.
- The prescaler counts 0..PRESCALE-1 and wraps. A tick occurs on the cycle where the count equals PRESCALE-1. The prescaler is cleared to 0 on Start acceptance and on the cycle rise is seen in WAIT_RISE.
- State machine:
  - IDLE: Start=1 → WAIT_RISE; clear the tick counter and the prescaler.
  - WAIT_RISE:
    - rise → MEASURE; the tick counter is cleared in the same cycle.
    - tick counter reaches TIMEOUT → REPORT, with Width=0 and Timeout=1.
    - If PulseIn is already high when the block is armed, a low must be seen first; a level alone is not a rise.
  - MEASURE:
    - The tick counter increments on each tick.
    - fall → REPORT, with Width = counter and Timeout=0.
    - Counter reaches TIMEOUT → REPORT, with Width=TIMEOUT and Timeout=1.
    - If fall and the TIMEOUT condition occur in the same cycle, fall wins and Timeout=0.
  - REPORT: Done=1 for exactly one cycle, then → IDLE.
- Start while Busy=1 is ignored; it is not queued.
- Width arithmetic: the counter is WIDTH bits wide and saturates at TIMEOUT, so it never wraps.
- Reset values: Busy=0, Done=0, Width=0, Timeout=0, state=IDLE, synchronizer flops=0.
- ResetN asserted mid-measurement:
  - Aborts immediately to IDLE with no Done strobe.
  - All outputs return to their reset values.

## Timing
- Start sampled high at edge k → Busy high after edge k.
- PulseIn sampled high at edge k → rise seen during cycle k+1 → MEASURE entered at edge k+2.
- PulseIn sampled low at edge k → Done high from edge k+2 to edge k+3; Busy low after edge k+3.
- Both pulse edges see the same synchronizer delay, so Width = floor(high cycles / PRESCALE). The quantization error lies in [0, 1) tick.
- Minimum detectable high or low phase: 2 ClockIn cycles.
- Back-to-back measurements: Start may be reasserted in the cycle after Done.

## Configuration
- PULSE_WIDTH_METER_AVG_EN defined:
  - Width reports (sum of the last 4 non-timeout measurements) >> 2.
  - A 4-entry history holds the measurements; it is cleared by reset.
  - Until 4 samples exist, empty entries count as 0.
  - The sum is WIDTH+2 bits wide.
  - Timeout measurements are not entered into the history; Width on a timeout Done is the current average and Timeout=1.
- PULSE_WIDTH_METER_AVG_EN undefined:
  - Width is the raw per-measurement value.
  - No history registers exist.

## Test plan
All scenarios use PRESCALE=5, WIDTH=16, TIMEOUT=100.
- Reset, then Start, then PulseIn high for 23 cycles → one Done with Width=4 and Timeout=0; Busy drops the cycle after Done.
- Start with PulseIn held low for 600 cycles → Done after 100 ticks with Width=0 and Timeout=1.
- Start, then PulseIn high for 1000 cycles → Done with Width=100 and Timeout=1; no wrap.
- PulseIn already high at Start, falls, then rises for 50 cycles → Width=10; the initial high level is not measured.
- Start pulsed while MEASURE is active → exactly one Done. Separately, ResetN pulsed low mid-MEASURE → all outputs 0, no Done, block returns to IDLE.
- With AVG_EN, four pulses of 50, 50, 100 and 100 cycles → the fourth Done reports Width=15.

Source files
------------

// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//
// Measures the high time of a slow external pulse (e.g. an ultrasonic echo)
// in prescaled ticks of ClockIn. After a Start, the block waits for a rising
// edge of PulseIn and counts ticks until the falling edge. It then reports the
// result with a one-cycle Done strobe. Both phases give up after TIMEOUT ticks.
//
// Parameters
//   PRESCALE  ClockIn cycles per measurement tick (>= 2)
//   WIDTH     width of the tick counter and of Width
//   TIMEOUT   tick limit for the wait and measure phases (< 2**WIDTH)
//
// Ports
//   ClockIn   in   system clock, rising edge
//   ResetN    in   asynchronous active-low reset
//   Start     in   one-cycle arm request, honoured only while idle
//   PulseIn   in   asynchronous pulse being measured
//   Busy      out  high in every state except IDLE
//   Done      out  one-cycle result strobe
//   Width     out  measured tick count, held until the next Done
//   Timeout   out  last measurement timed out, held until the next Done
//
// Build option
//   PULSE_WIDTH_METER_AVG_EN  when defined, Width reports the mean of the
//                             last four non-timeout measurements. A timeout
//                             reports the current mean, and the history is
//                             left unchanged.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for Start
// WAIT_RISE | armed; waiting for a low-to-high edge on PulseIn
// MEASURE   | counting ticks while PulseIn is high
// REPORT    | Done strobe cycle; returns to IDLE

module pulse_width_meter #(
    parameter int PRESCALE = 50,
    parameter int WIDTH    = 16,
    parameter int TIMEOUT  = 30000
) (
    input  logic             ClockIn,
    input  logic             ResetN,
    input  logic             Start,
    input  logic             PulseIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Width,
    output logic             Timeout
);

    localparam int               PW            = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] TIMEOUT_VAL   = WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEASURE,
        REPORT
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [PW-1:0]    preCount;
    logic [WIDTH-1:0] tickCount;
    logic             rise;
    logic             fall;
    logic             tick;
    logic             atLimit;
    logic [WIDTH-1:0] fallValue;
    logic [WIDTH-1:0] widthFall;
    logic [WIDTH-1:0] widthWaitTimeout;
    logic [WIDTH-1:0] widthMeasTimeout;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign tick    = (preCount == PRESCALE_LAST);
    assign atLimit = (tickCount == TIMEOUT_VAL);

    // A tick that lands in the fall cycle is counted. The fall cycle is the
    // last high cycle seen through the synchronizer, so including it makes
    // the result floor(high cycles / PRESCALE). The count saturates at TIMEOUT.
    assign fallValue = (tick && !atLimit) ? tickCount + 1'b1 : tickCount;

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= PulseIn;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef PULSE_WIDTH_METER_AVG_EN
    logic [3:0][WIDTH-1:0] hist;
    logic [WIDTH+1:0]      sumFall;
    logic [WIDTH+1:0]      sumHist;

    // The fall result must already include the new sample, so the sum is
    // formed from the incoming value plus the three newest stored entries.
    assign sumFall = {2'b00, fallValue} + {2'b00, hist[0]}
                   + {2'b00, hist[1]}   + {2'b00, hist[2]};
    assign sumHist = {2'b00, hist[0]} + {2'b00, hist[1]}
                   + {2'b00, hist[2]} + {2'b00, hist[3]};

    assign widthFall        = sumFall[WIDTH+1:2];
    assign widthWaitTimeout = sumHist[WIDTH+1:2];
    assign widthMeasTimeout = sumHist[WIDTH+1:2];

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            hist <= '0;
        end else if (state == MEASURE && fall) begin
            hist <= {hist[2:0], fallValue};
        end
    end
`else
    assign widthFall        = fallValue;
    assign widthWaitTimeout = '0;
    assign widthMeasTimeout = TIMEOUT_VAL;
`endif

    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            state     <= IDLE;
            preCount  <= '0;
            tickCount <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Width     <= '0;
            Timeout   <= 1'b0;
        end else begin
            Done     <= 1'b0;
            preCount <= tick ? '0 : preCount + 1'b1;
            if (tick && !atLimit) begin
                tickCount <= tickCount + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (Start) begin
                        state     <= WAIT_RISE;
                        Busy      <= 1'b1;
                        preCount  <= '0;
                        tickCount <= '0;
                    end
                end

                WAIT_RISE: begin
                    if (rise) begin
                        state     <= MEASURE;
                        preCount  <= '0;
                        tickCount <= '0;
                    end else if (atLimit) begin
                        state   <= REPORT;
                        Done    <= 1'b1;
                        Width   <= widthWaitTimeout;
                        Timeout <= 1'b1;
                    end
                end

                MEASURE: begin
                    if (fall) begin
                        state   <= REPORT;
                        Done    <= 1'b1;
                        Width   <= widthFall;
                        Timeout <= 1'b0;
                    end else if (atLimit) begin
                        state   <= REPORT;
                        Done    <= 1'b1;
                        Width   <= widthMeasTimeout;
                        Timeout <= 1'b1;
                    end
                end

                REPORT: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
